// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: byte-lane placement of store data, extension of load data,
// and optional two-cycle split of accesses that cross a 32-bit word boundary.
module lsu_align_ctrl #(
    parameter bit          MISALIGN_EN = 1'b1,
    parameter int unsigned AW          = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   store_data,
    output logic [31:0]   load_data,
    output logic          load_valid,
    output logic          stall,
    output logic          misalign_err,
    output logic          mem_cs,
    output logic          mem_wr,
    output logic [3:0]    mem_mask,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   low_q;
    logic [1:0]    off;
    logic [4:0]    sh_lo;
    logic [5:0]    sh_hi;
    logic [3:0]    size;
    logic [3:0]    byte_en;
    logic [7:0]    lane_mask;
    logic [63:0]   lane_data;
    logic [AW-1:0] word;
    logic          illegal;
    logic          crossing;
    logic          split;
    logic          addr_unused;

    assign off         = req_addr[1:0];
    assign word        = req_addr[AW+1:2];
    assign sh_lo       = {off, 3'b000};
    assign sh_hi       = 6'd32 - {1'b0, sh_lo};
    assign addr_unused = ^req_addr[31:AW+2];

    // Access size in bytes and its unshifted byte-enable pattern
    always_comb begin
        size    = 4'd4;
        byte_en = 4'b1111;
        case (funct3[1:0])
            2'b00:   begin size = 4'd1; byte_en = 4'b0001; end
            2'b01:   begin size = 4'd2; byte_en = 4'b0011; end
            default: ;
        endcase
    end

    assign illegal  = req_we ? (funct3[2] | (funct3[1:0] == 2'b11))
                             : ((funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11));
    assign crossing = ({2'b00, off} + size) > 4'd4;

    // Lower half feeds the first word, upper half spills into the next word
    assign lane_mask = 8'({4'b0000, byte_en} << off);
    assign lane_data = {32'h0, store_data} << sh_lo;

    assign split = (state == IDLE) & req_valid & ~illegal & crossing & MISALIGN_EN;

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] x);
        case (f)
            3'b000:  extend = {{24{x[7]}}, x[7:0]};
            3'b100:  extend = {24'h0, x[7:0]};
            3'b001:  extend = {{16{x[15]}}, x[15:0]};
            3'b101:  extend = {16'h0, x[15:0]};
            default: extend = x;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  low_q <= 32'h0;
        else if (split & ~req_we) low_q <= mem_rdata >> sh_lo;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (split) state_next = SECOND;
            SECOND:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory controls and core handshake are combinational so they settle before the negedge write
    always_comb begin
        stall        = 1'b0;
        load_valid   = 1'b0;
        misalign_err = 1'b0;
        mem_cs       = 1'b1;
        mem_wr       = 1'b1;
        mem_mask     = 4'h0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        load_data    = 32'h0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal || (crossing && !MISALIGN_EN)) begin
                            misalign_err = 1'b1;
                        end else begin
                            mem_cs    = 1'b0;
                            mem_wr    = ~req_we;
                            mem_addr  = word;
                            mem_mask  = req_we ? lane_mask[3:0] : 4'h0;
                            mem_wdata = lane_data[31:0];
                            if (crossing) begin
                                stall = 1'b1;
                            end else if (!req_we) begin
                                load_valid = 1'b1;
                                load_data  = extend(funct3, mem_rdata >> sh_lo);
                            end
                        end
                    end
                end
                SECOND: begin
                    mem_cs    = 1'b0;
                    mem_wr    = ~req_we;
                    mem_addr  = word + AW'(1);
                    mem_mask  = req_we ? lane_mask[7:4] : 4'h0;
                    mem_wdata = lane_data[63:32];
                    if (!req_we) begin
                        load_valid = 1'b1;
                        load_data  = extend(funct3, low_q | (mem_rdata << sh_hi));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl: vector table for single-cycle accesses plus
// hand-written split, wrap, reset-in-SECOND and MISALIGN_EN=0 sequences.
module tb_lsu_align_ctrl;

    logic        clk;
    logic        rst;
    logic        fill;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] req_addr;
    logic [31:0] store_data;

    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        misalign_err;
    logic        mem_cs;
    logic        mem_wr;
    logic [3:0]  mem_mask;
    logic [20:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] e0_load_data;
    logic        e0_load_valid;
    logic        e0_stall;
    logic        e0_misalign_err;
    logic        e0_mem_cs;
    logic        e0_mem_wr;
    logic [3:0]  e0_mem_mask;
    logic [20:0] e0_mem_addr;
    logic [31:0] e0_mem_wdata;
    logic [31:0] e0_mem_rdata;

    logic [31:0] mem [256];

    int checks;
    int failures;

    lsu_align_ctrl #(.MISALIGN_EN(1'b1), .AW(21)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
        .req_addr(req_addr), .store_data(store_data), .load_data(load_data),
        .load_valid(load_valid), .stall(stall), .misalign_err(misalign_err),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_align_ctrl #(.MISALIGN_EN(1'b0), .AW(21)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
        .req_addr(req_addr), .store_data(store_data), .load_data(e0_load_data),
        .load_valid(e0_load_valid), .stall(e0_stall), .misalign_err(e0_misalign_err),
        .mem_cs(e0_mem_cs), .mem_wr(e0_mem_wr), .mem_mask(e0_mem_mask), .mem_addr(e0_mem_addr),
        .mem_wdata(e0_mem_wdata), .mem_rdata(e0_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: async read, masked write on negedge, indexed by low address bits
    assign mem_rdata    = mem[mem_addr[7:0]];
    assign e0_mem_rdata = 32'h12345678;

    always @(negedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hBABECAFE;
        end else if (!mem_cs && !mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        funct3     = f3;
        req_addr   = a;
        store_data = d;
    endtask

    typedef struct {
        logic        valid;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        cs;
        logic        wr;
        logic [20:0] maddr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        stall;
        logic        lv;
        logic [31:0] ld;
        logic        err;
    } vec_t;

    localparam int unsigned NVEC = 12;
    vec_t vecs [NVEC];

    initial begin
        checks   = 0;
        failures = 0;

        //            valid we  f3      addr      sdata         cs wr maddr   mask     wdata         st lv ld            err
        vecs[0]  = '{1'b1,1'b1,3'b010,32'h100,32'h11223344, 1'b0,1'b0,21'h40,4'b1111,32'h11223344,1'b0,1'b0,32'h0,       1'b0};
        vecs[1]  = '{1'b1,1'b0,3'b001,32'h102,32'h0,        1'b0,1'b1,21'h40,4'b0000,32'h0,       1'b0,1'b1,32'h00001122,1'b0};
        vecs[2]  = '{1'b1,1'b0,3'b000,32'h103,32'h0,        1'b0,1'b1,21'h40,4'b0000,32'h0,       1'b0,1'b1,32'h00000011,1'b0};
        vecs[3]  = '{1'b1,1'b0,3'b100,32'h100,32'h0,        1'b0,1'b1,21'h40,4'b0000,32'h0,       1'b0,1'b1,32'h00000044,1'b0};
        vecs[4]  = '{1'b1,1'b0,3'b011,32'h104,32'h0,        1'b1,1'b1,21'h0, 4'b0000,32'h0,       1'b0,1'b0,32'h0,       1'b1};
        vecs[5]  = '{1'b1,1'b1,3'b100,32'h100,32'hFFFFFFFF, 1'b1,1'b1,21'h0, 4'b0000,32'h0,       1'b0,1'b0,32'h0,       1'b1};
        vecs[6]  = '{1'b1,1'b1,3'b000,32'h101,32'h000000A5, 1'b0,1'b0,21'h40,4'b0010,32'h0000A500,1'b0,1'b0,32'h0,       1'b0};
        vecs[7]  = '{1'b1,1'b0,3'b000,32'h101,32'h0,        1'b0,1'b1,21'h40,4'b0000,32'h0,       1'b0,1'b1,32'hFFFFFFA5,1'b0};
        vecs[8]  = '{1'b1,1'b1,3'b001,32'h10A,32'h1234BEEF, 1'b0,1'b0,21'h42,4'b1100,32'hBEEF0000,1'b0,1'b0,32'h0,       1'b0};
        vecs[9]  = '{1'b0,1'b0,3'b010,32'h100,32'h0,        1'b1,1'b1,21'h0, 4'b0000,32'h0,       1'b0,1'b0,32'h0,       1'b0};
        vecs[10] = '{1'b1,1'b0,3'b101,32'h10A,32'h0,        1'b0,1'b1,21'h42,4'b0000,32'h0,       1'b0,1'b1,32'h0000BEEF,1'b0};
        vecs[11] = '{1'b1,1'b0,3'b001,32'h10A,32'h0,        1'b0,1'b1,21'h42,4'b0000,32'h0,       1'b0,1'b1,32'hFFFFBEEF,1'b0};

        // Reset: outputs forced idle even with a legal request presented
        rst  = 1'b1;
        fill = 1'b1;
        drive(1'b1, 1'b1, 3'b010, 32'h100, 32'h11223344);
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",   32'(stall), 32'h0);
        check("rst_lv",      32'(load_valid), 32'h0);
        check("rst_err",     32'(misalign_err), 32'h0);
        check("rst_cs",      32'(mem_cs), 32'h1);
        check("rst_wr",      32'(mem_wr), 32'h1);
        check("rst_mask",    32'(mem_mask), 32'h0);
        check("rst_addr",    32'(mem_addr), 32'h0);
        check("rst_wdata",   mem_wdata, 32'h0);
        check("rst_ld",      load_data, 32'h0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        fill = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // Single-cycle vector table
        for (int i = 0; i < int'(NVEC); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].valid, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].sdata);
            #1;
            check($sformatf("v%0d_cs", i),    32'(mem_cs), 32'(vecs[i].cs));
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].stall));
            check($sformatf("v%0d_lv", i),    32'(load_valid), 32'(vecs[i].lv));
            check($sformatf("v%0d_err", i),   32'(misalign_err), 32'(vecs[i].err));
            if (!vecs[i].err) check($sformatf("v%0d_mask", i), 32'(mem_mask), 32'(vecs[i].mask));
            if (!vecs[i].cs) begin
                check($sformatf("v%0d_wr", i),   32'(mem_wr), 32'(vecs[i].wr));
                check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            end
            if (!vecs[i].cs && vecs[i].we) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
            if (vecs[i].lv) check($sformatf("v%0d_ld", i), load_data, vecs[i].ld);
        end

        // Crossing store SW 0xAABBCCDD at 0x1FE
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 3'b010, 32'h1FE, 32'hAABBCCDD);
        #1;
        check("sw1fe_c1_cs",    32'(mem_cs), 32'h0);
        check("sw1fe_c1_wr",    32'(mem_wr), 32'h0);
        check("sw1fe_c1_addr",  32'(mem_addr), 32'h7F);
        check("sw1fe_c1_mask",  32'(mem_mask), 32'hC);
        check("sw1fe_c1_wdata", mem_wdata, 32'hCCDD0000);
        check("sw1fe_c1_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #2;
        check("sw1fe_c2_cs",    32'(mem_cs), 32'h0);
        check("sw1fe_c2_addr",  32'(mem_addr), 32'h80);
        check("sw1fe_c2_mask",  32'(mem_mask), 32'h3);
        check("sw1fe_c2_wdata", mem_wdata, 32'h0000AABB);
        check("sw1fe_c2_stall", 32'(stall), 32'h0);

        // Crossing load LW 0x1FE reassembles the split store
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b010, 32'h1FE, 32'h0);
        #1;
        check("lw1fe_c1_stall", 32'(stall), 32'h1);
        check("lw1fe_c1_lv",    32'(load_valid), 32'h0);
        check("lw1fe_c1_addr",  32'(mem_addr), 32'h7F);
        @(posedge clk);
        #2;
        check("lw1fe_c2_addr",  32'(mem_addr), 32'h80);
        check("lw1fe_c2_stall", 32'(stall), 32'h0);
        check("lw1fe_c2_lv",    32'(load_valid), 32'h1);
        check("lw1fe_c2_ld",    load_data, 32'hAABBCCDD);

        // Crossing halfword loads at 0x103, signed and unsigned
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b001, 32'h103, 32'h0);
        #1;
        check("lh103_c1_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #2;
        check("lh103_lv", 32'(load_valid), 32'h1);
        check("lh103_ld", load_data, 32'hFFFFFE11);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b101, 32'h103, 32'h0);
        @(posedge clk);
        #2;
        check("lhu103_lv", 32'(load_valid), 32'h1);
        check("lhu103_ld", load_data, 32'h0000FE11);

        // Word address wrap on the second half
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 3'b010, 32'h7FFFFE, 32'h01020304);
        #1;
        check("wrap_c1_addr",  32'(mem_addr), 32'h1FFFFF);
        check("wrap_c1_mask",  32'(mem_mask), 32'hC);
        check("wrap_c1_wdata", mem_wdata, 32'h03040000);
        @(posedge clk);
        #2;
        check("wrap_c2_addr",  32'(mem_addr), 32'h0);
        check("wrap_c2_mask",  32'(mem_mask), 32'h3);
        check("wrap_c2_wdata", mem_wdata, 32'h00000102);

        // MISALIGN_EN=0 instance rejects crossing LW 0x101
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        #1;
        check("noal_err",   32'(e0_misalign_err), 32'h1);
        check("noal_cs",    32'(e0_mem_cs), 32'h1);
        check("noal_stall", 32'(e0_stall), 32'h0);
        check("noal_lv",    32'(e0_load_valid), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        check("noal_lw_err", 32'(e0_misalign_err), 32'h0);
        check("noal_lw_cs",  32'(e0_mem_cs), 32'h0);
        check("noal_lw_lv",  32'(e0_load_valid), 32'h1);
        check("noal_lw_ld",  e0_load_data, 32'h12345678);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b100, 32'h102, 32'h0);
        #1;
        check("noal_lbu_ld", e0_load_data, 32'h00000034);

        // Reset in SECOND: second half is dropped, first half already written
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 3'b010, 32'h203, 32'hDEADBEEF);
        #1;
        check("rs_c1_stall", 32'(stall), 32'h1);
        check("rs_c1_mask",  32'(mem_mask), 32'h8);
        check("rs_c1_wdata", mem_wdata, 32'hEF000000);
        check("rs_c1_addr",  32'(mem_addr), 32'h80);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        check("rs_cs",    32'(mem_cs), 32'h1);
        check("rs_stall", 32'(stall), 32'h0);
        check("rs_mask",  32'(mem_mask), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rs_mem80", mem[8'h80], 32'hEFBEAABB);
        check("rs_mem81", mem[8'h81], 32'hBABECAFE);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'b010, 32'h204, 32'h0);
        #1;
        check("rs_after_addr",  32'(mem_addr), 32'h81);
        check("rs_after_stall", 32'(stall), 32'h0);
        check("rs_after_lv",    32'(load_valid), 32'h1);
        check("rs_after_ld",    load_data, 32'hBABECAFE);

        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_align_ctrl.md
Name: lsu_align_ctrl

Overview:
- Load/store alignment controller between the core's execute stage and the data memory.
- Produces the memory controls: active-low chip select, write (low = write), byte mask and 21-bit word address.
- Shifts store data into byte lanes. Extracts and sign/zero-extends load data from the asynchronous read port.
- Splits misaligned accesses that cross a word boundary into two memory cycles, stalling the core for one extra cycle.

Parameters:
- MISALIGN_EN, 1: 1 = split boundary-crossing accesses in hardware; 0 = reject them with misalign_err and no memory access.
- AW, 21: word-address width driven to memory.

Ports:
- clk  in  1  core clock; memory writes on negedge, this block updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  load/store request present this cycle
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- store_data  in  32  rs2 value
- load_data  out  32  extended load result, valid when load_valid=1
- load_valid  out  1  load completes this cycle
- stall  out  1  core must hold PC and all req_* inputs stable
- misalign_err  out  1  one-cycle error flag (illegal funct3, or crossing access with MISALIGN_EN=0)
- mem_cs  out  1  active-low chip select
- mem_wr  out  1  0 = write, 1 = read
- mem_mask  out  4  byte-lane write enables
- mem_addr  out  AW  word address
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  asynchronous read data

Behaviour:
- Reset (async): state=IDLE; captured-low register=0.
- Outputs during reset: stall=0, load_valid=0, misalign_err=0, mem_cs=1, mem_wr=1, mem_mask=0, mem_addr=0, mem_wdata=0, load_data=0.
- Size n = 1/2/4 from funct3[1:0]. Byte offset o = req_addr[1:0]. Word w = req_addr[AW+1:2].
- Crossing access: o+n > 4.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value with funct3[2]=1, or 011.
  - Response: misalign_err=1, mem_cs=1, no stall.
- FSM states: IDLE, SECOND.
- IDLE, req_valid=0: mem_cs=1, mem_mask=0.
- IDLE, aligned or non-crossing access, single cycle:
  - Memory drive: mem_cs=0, mem_addr=w, mem_mask=((1<<n)-1)<<o for stores and 0 for loads, mem_wr=~req_we, mem_wdata=store_data<<(8*o).
  - Load result: load_data=extend(mem_rdata>>(8*o)) combinationally, load_valid=1, stall=0.
- IDLE, crossing access, MISALIGN_EN=1, first cycle:
  - Memory drive: mem_addr=w, mem_mask=(0xF<<o)&0xF, mem_wdata=store_data<<(8*o).
  - Loads capture mem_rdata>>(8*o) into the low register at posedge.
  - stall=1, load_valid=0. Next state SECOND.
- SECOND, second cycle:
  - Memory drive: mem_addr=w+1, wrapping modulo 2^AW (0x1FFFFF+1 → 0). mem_mask=(1<<(o+n-4))-1. mem_wdata=store_data>>(8*(4-o)).
  - Loads: load_data=extend(low | (mem_rdata<<(8*(4-o)))), load_valid=1.
  - stall=0. Next state IDLE.
- SECOND ignores req_valid. The core guarantees inputs are held stable; the block does not re-sample them.
- IDLE, crossing access, MISALIGN_EN=0: misalign_err=1, mem_cs=1, no stall.
- extend(x): B = sign-extend x[7:0]; BU = zero-extend x[7:0]; H/HU likewise on x[15:0]; W = x.
- Reset asserted in SECOND: immediate return to IDLE; second half is not issued. A first-half store already written stays in memory.
- All memory outputs are combinational from state and registered/held inputs, so they are stable before the memory's negedge write.

Test Plan:
- Reset, then SW 0x11223344 at 0x100 → mem_cs=0, mem_wr=0, mem_addr=0x40, mem_mask=1111, mem_wdata=0x11223344, stall=0.
- After that store: LH 0x102 → 0x00001122. LB 0x103 → 0x00000011. LBU 0x100 → 0x00000044. Each takes one cycle, load_valid=1.
- SW 0xAABBCCDD at 0x1FE:
  - Cycle 1: mem_addr=0x7F, mask=1100, wdata=0xCCDD0000, stall=1.
  - Cycle 2: mem_addr=0x80, mask=0011, wdata=0x0000AABB, stall=0.
  - Then LW 0x1FE → 2 cycles, load_data=0xAABBCCDD.
- Memory filled 0xBABECAFE, word 0x40=0x11223344: LH 0x103 → 0xFFFFFE11. LHU 0x103 → 0x0000FE11.
- SW 0x01020304 at 0x7FFFFE: second cycle mem_addr=0x000000, mask=0011.
- Boundary cases:
  - Rst asserted during SECOND of a crossing store → mem_cs=1 at once; only the first-half bytes changed.
  - MISALIGN_EN=0 with LW 0x101 → misalign_err=1, mem_cs=1.
  - funct3=011 → misalign_err=1, no access.
